// File: rtl/dcache_wb.sv
// dcache_wb -- N-way set-associative write-back data cache for the MEM stage.
//
// Hits finish combinationally in the request cycle. On a miss the cache
// raises `miss` (pipeline stall). A small FSM first writes back a dirty
// victim line word by word, then refills the missed line word by word over
// the req/ack memory port. Allocation is on both read and write misses.
//
// Optional feature macro: DCACHE_STAT_EN
//   defined   -> hit_cnt / miss_cnt are live 32-bit wrapping counters
//   undefined -> hit_cnt / miss_cnt are tied to 0, no counter registers
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   addr               byte address {.., tag, index, word, 2'b--}
//   wr_data            store data
//   MemWrite, MemRead  store / load request (both high = store)
//   rd_data            load data, valid when MemRead=1 and miss=0
//   miss               stall request to the pipeline
//   mem_req, mem_we    memory transfer request, 1=write-back 0=refill
//   mem_addr           word-aligned memory address
//   mem_wdata          write-back data
//   mem_rdata, mem_ack refill data and per-word completion
//   hit_cnt, miss_cnt  statistics counters
module dcache_wb #(
  parameter int WAY_ADDR_LEN      = 1,
  parameter int INDEX_ADDR_LEN    = 6,
  parameter int LINEWORD_ADDR_LEN = 2,
  parameter int TAG_LEN           = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int WAYS      = 1 << WAY_ADDR_LEN;
  localparam int SETS      = 1 << INDEX_ADDR_LEN;
  localparam int WORDS     = 1 << LINEWORD_ADDR_LEN;
  localparam int IDX_LO    = 2 + LINEWORD_ADDR_LEN;
  localparam int TAG_LO    = IDX_LO + INDEX_ADDR_LEN;
  localparam int ADDR_USED = TAG_LO + TAG_LEN;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  // state is kept as a named enum so checkers can bind to it directly.
  state_t state, state_nxt;

  // Line storage.
  logic [WAYS-1:0]         valid_q [SETS];
  logic [WAYS-1:0]         dirty_q [SETS];
  logic [WAY_ADDR_LEN-1:0] ptr_q   [SETS];
  logic [TAG_LEN-1:0]      tag_q   [WAYS][SETS];
  logic [31:0]             data_q  [WAYS][SETS][WORDS];

  // Transaction context captured on leaving IDLE.
  logic [WAY_ADDR_LEN-1:0]      lat_way;
  logic [TAG_LEN-1:0]           lat_vtag;
  logic [TAG_LEN-1:0]           lat_rtag;
  logic [INDEX_ADDR_LEN-1:0]    lat_idx;
  logic [LINEWORD_ADDR_LEN-1:0] k;
  logic                         k_last;

  // Request address fields.
  logic [LINEWORD_ADDR_LEN-1:0] req_word;
  logic [INDEX_ADDR_LEN-1:0]    req_idx;
  logic [TAG_LEN-1:0]           req_tag;
  logic                         req;

  logic                    hit;
  logic [WAY_ADDR_LEN-1:0] hit_way;
  logic [WAY_ADDR_LEN-1:0] vic_way;
  logic                    vic_dirty;
  logic                    start_miss;

  logic unused_addr_bits;

  assign req_word = addr[IDX_LO-1:2];
  assign req_idx  = addr[TAG_LO-1:IDX_LO];
  assign req_tag  = addr[ADDR_USED-1:TAG_LO];
  assign req      = MemRead | MemWrite;
  assign k_last   = &k;

  assign unused_addr_bits = ^{addr[31:ADDR_USED], addr[1:0]};

  // Hit detection: only meaningful in IDLE; lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_ADDR_LEN'(w);
      end
    end
    if (state != IDLE) hit = 1'b0;
  end

  // Victim: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    vic_way = ptr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) vic_way = WAY_ADDR_LEN'(w);
    end
  end

  assign vic_dirty  = valid_q[req_idx][vic_way] & dirty_q[req_idx][vic_way];
  assign start_miss = (state == IDLE) && req && !hit;

  // Without a hit, hit_way is 0, so rd_data falls back to way 0's word.
  assign rd_data = data_q[hit_way][req_idx][req_word];
  assign miss    = (state == IDLE) ? (req & ~hit) : 1'b1;

  // Memory handshake: mem_req is a valid that stays high for the whole
  // WB/FILL sequence; mem_addr/mem_we/mem_wdata only move when mem_ack
  // (the ready) completes a word at the rising edge, so they are stable
  // while mem_req=1 and mem_ack=0. One word completes per ack cycle.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (start_miss) state_nxt = vic_dirty ? WB : FILL;
      end
      WB: begin
        mem_req                   = 1'b1;
        mem_we                    = 1'b1;
        mem_addr[ADDR_USED-1:0]   = {lat_vtag, lat_idx, k, 2'b00};
        mem_wdata                 = data_q[lat_way][lat_idx][k];
        if (mem_ack && k_last) state_nxt = FILL;
      end
      FILL: begin
        mem_req                   = 1'b1;
        mem_addr[ADDR_USED-1:0]   = {lat_rtag, lat_idx, k, 2'b00};
        if (mem_ack && k_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control state: valid/dirty/pointers and the word counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start_miss) begin
            k <= '0;
            // The victim is being replaced; it must not hit until refilled.
            valid_q[req_idx][vic_way] <= 1'b0;
          end else if (req && MemWrite && hit) begin
            dirty_q[req_idx][hit_way] <= 1'b1;
          end
        end
        WB: begin
          if (mem_ack) k <= k + LINEWORD_ADDR_LEN'(1);
        end
        FILL: begin
          if (mem_ack) begin
            k <= k + LINEWORD_ADDR_LEN'(1);
            if (k_last) begin
              valid_q[lat_idx][lat_way] <= 1'b1;
              dirty_q[lat_idx][lat_way] <= 1'b0;
              ptr_q[lat_idx]            <= ptr_q[lat_idx] + WAY_ADDR_LEN'(1);
            end
          end
        end
        default: k <= '0;
      endcase
    end
  end

  // Datapath storage and transaction context (not reset).
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (start_miss) begin
        lat_way  <= vic_way;
        lat_vtag <= tag_q[vic_way][req_idx];
        lat_rtag <= req_tag;
        lat_idx  <= req_idx;
      end
      if (req && MemWrite && hit) data_q[hit_way][req_idx][req_word] <= wr_data;
      if ((state == FILL) && mem_ack) begin
        data_q[lat_way][lat_idx][k] <= mem_rdata;
        if (k_last) tag_q[lat_way][lat_idx] <= lat_rtag;
      end
    end
  end

`ifdef DCACHE_STAT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (req && !miss) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (start_miss)   miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Testbench for dcache_wb: directed accesses against a zero/N-wait memory
// model that returns mem_rdata = mem_addr. Completed memory words are
// logged and compared against a hand-built expected queue.
module tb_dcache_wb;

  localparam int EW = 65; // {we, addr, wdata}

  logic        clk;
  logic        rstn;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act_q[$];

  dcache_wb dut (
    .clk       (clk),
    .rstn      (rstn),
    .addr      (addr),
    .wr_data   (wr_data),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .rd_data   (rd_data),
    .miss      (miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  int wait_cycles = 0;
  int wait_cnt    = 0;

  assign mem_rdata = mem_addr;
  assign mem_ack   = mem_req && (wait_cnt >= wait_cycles);

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- monitor: word log + handshake stability ----------------
  logic        prev_wait  = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] prev_wdata = '0;
  logic        prev_we    = 1'b0;

  always @(negedge clk) begin
    if (mem_req && prev_wait) begin
      check("mem_addr_stable", mem_addr, prev_addr);
      check("mem_we_stable", {31'b0, mem_we}, {31'b0, prev_we});
      check("mem_wdata_stable", mem_wdata, prev_wdata);
    end
    prev_wait  <= mem_req && !mem_ack;
    prev_addr  <= mem_addr;
    prev_we    <= mem_we;
    prev_wdata <= mem_wdata;
    if (mem_req && mem_ack) act_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
  end

  // ---------------- driver tasks ----------------
  // Starts just after a rising edge; holds the request until it hits,
  // samples rd_data in the hit cycle, releases just after the next edge.
  task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output int mcyc, output logic [31:0] rd);
    mcyc     = 0;
    addr     = a;
    wr_data  = wd;
    MemWrite = we;
    MemRead  = !we;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!miss) break;
      mcyc++;
    end
    rd = rd_data;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  task automatic expect_line(input logic we, input logic [31:0] base, input logic [31:0] w1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = base + 32'(i * 4);
      if (!we)        exp_q.push_back({1'b0, a, 32'h0});
      else if (i == 1) exp_q.push_back({1'b1, a, w1});
      else            exp_q.push_back({1'b1, a, a});
    end
  endtask

  task automatic drain(input string tag);
    logic [EW-1:0] e;
    logic [EW-1:0] g;
    check({tag, "_nwords"}, 32'(act_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (act_q.size() > 0) ? act_q.pop_front() : '1;
      check({tag, "_we"},    {31'b0, g[64]}, {31'b0, e[64]});
      check({tag, "_addr"},  g[63:32], e[63:32]);
      check({tag, "_wdata"}, g[31:0],  e[31:0]);
    end
    act_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int          mc;
    logic [31:0] rd;

    rstn     = 1'b0;
    addr     = '0;
    wr_data  = '0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    @(negedge clk);
    check("rst_miss", {31'b0, miss}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_hit_cnt", hit_cnt, 32'h0);
    check("rst_miss_cnt", miss_cnt, 32'h0);
    @(posedge clk);
    #1;

    // Cold read miss: clean refill of line 0x000.
    do_access(1'b0, 32'h000, 32'h0, mc, rd);
    check("cold_miss_cycles", 32'(mc), 32'd5);
    check("cold_rd", rd, 32'h0);
    expect_line(1'b0, 32'h000, 32'h0);
    drain("cold");

    do_access(1'b0, 32'h008, 32'h0, mc, rd);
    check("hit8_miss_cycles", 32'(mc), 32'd0);
    check("hit8_rd", rd, 32'h8);
    drain("hit8");

    // Write hit then read back.
    do_access(1'b1, 32'h004, 32'hDEADBEEF, mc, rd);
    check("wrhit_miss_cycles", 32'(mc), 32'd0);
    do_access(1'b0, 32'h004, 32'h0, mc, rd);
    check("wrhit_rd", rd, 32'hDEADBEEF);
    drain("wrhit");

    // Fill way1, then evict dirty way0.
    do_access(1'b0, 32'h400, 32'h0, mc, rd);
    check("way1_miss_cycles", 32'(mc), 32'd5);
    check("way1_rd", rd, 32'h400);
    expect_line(1'b0, 32'h400, 32'h0);
    drain("way1");

    do_access(1'b0, 32'h800, 32'h0, mc, rd);
    check("dirty_miss_cycles", 32'(mc), 32'd9);
    check("dirty_rd", rd, 32'h800);
    expect_line(1'b1, 32'h000, 32'hDEADBEEF);
    expect_line(1'b0, 32'h800, 32'h0);
    drain("dirty");

    // Write-allocate miss.
    do_access(1'b1, 32'hC14, 32'h12345678, mc, rd);
    check("wralloc_miss_cycles", 32'(mc), 32'd5);
    expect_line(1'b0, 32'hC10, 32'h0);
    drain("wralloc");
    do_access(1'b0, 32'hC14, 32'h0, mc, rd);
    check("wralloc_rd14", rd, 32'h12345678);
    do_access(1'b0, 32'hC18, 32'h0, mc, rd);
    check("wralloc_rd18", rd, 32'hC18);
    drain("wralloc_rd");

    // Slow memory: 3 wait cycles per word.
    wait_cycles = 3;
    do_access(1'b0, 32'h020, 32'h0, mc, rd);
    check("slow_miss_cycles", 32'(mc), 32'd17);
    check("slow_rd", rd, 32'h20);
    expect_line(1'b0, 32'h020, 32'h0);
    drain("slow");
    wait_cycles = 0;

`ifdef DCACHE_STAT_EN
    check("stat_hit_cnt", hit_cnt, 32'd10);
    check("stat_miss_cnt", miss_cnt, 32'd5);
`else
    check("stat_hit_cnt", hit_cnt, 32'd0);
    check("stat_miss_cnt", miss_cnt, 32'd0);
`endif

    // Reset in the middle of a refill of 0x000 (victim way1, clean).
    addr    = 32'h000;
    MemRead = 1'b1;
    @(posedge clk);         // IDLE -> FILL
    @(posedge clk);         // word 0 completes
    #1;
    check("midfill_mem_req", {31'b0, mem_req}, 32'h1);
    rstn    = 1'b0;
    MemRead = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("postrst_mem_req", {31'b0, mem_req}, 32'h0);
    check("postrst_miss", {31'b0, miss}, 32'h0);
    check("postrst_hit_cnt", hit_cnt, 32'h0);
    check("postrst_miss_cnt", miss_cnt, 32'h0);
    act_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;

    do_access(1'b0, 32'h000, 32'h0, mc, rd);
    check("refill_miss_cycles", 32'(mc), 32'd5);
    check("refill_rd", rd, 32'h0);
    expect_line(1'b0, 32'h000, 32'h0);
    drain("refill");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
